color_move_ctrl: RTL and testbench

- Downstream consumer of the colour-sensor command outputs (is_move, move[1:0]); turns them into the player sprite position for the VGA game renderer.
- Synchronises the command, which is produced asynchronously to the pixel clock, and filters out transient colour readings.
- Advances the position by a fixed step at a fixed rate, clamped to the playfield; pos_x/pos_y feed the VGA draw logic directly.

---
 rtl/color_game_pkg.sv | 10 +
 rtl/cmd_debounce.sv | 33 +++
 rtl/color_move_ctrl.sv | 112 +++++++++++
 tb/tb_color_move_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/color_game_pkg.sv
// color_game_pkg: direction codes shared with the colour stage, FSM states and screen geometry
package color_game_pkg;
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  typedef enum logic {S_IDLE = 1'b0, S_MOVE = 1'b1} state_t;
endpackage

// File: rtl/cmd_debounce.sv
// cmd_debounce: 2-flop synchroniser on the raw command plus a stability filter that
// pulses cmd_accept once a synchronised command has held for STABLE_CYCLES cycles
module cmd_debounce #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       is_move,
  input  logic [1:0] move,
  output logic       cmd_accept,
  output logic       acc_is_move,
  output logic [1:0] acc_move
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  logic [2:0]    r_sync1, r_cmd_s;
  logic [CW-1:0] r_stab_cnt;
  logic          w_change;
  // a change is seen as cmd_s is about to take a new value, which keeps latency at STABLE_CYCLES+2
  assign w_change = r_sync1 != r_cmd_s;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= '0;
      r_cmd_s    <= '0;
      r_stab_cnt <= '0;
    end else begin
      r_sync1    <= {is_move, move};
      r_cmd_s    <= r_sync1;
      r_stab_cnt <= w_change ? '0 : (r_stab_cnt == CW'(STABLE_CYCLES)) ? r_stab_cnt : r_stab_cnt + 1'b1;
    end
  end
  assign cmd_accept = !w_change && r_stab_cnt == CW'(STABLE_CYCLES - 1);
  assign {acc_is_move, acc_move} = r_cmd_s;
endmodule

// File: rtl/color_move_ctrl.sv
// color_move_ctrl: turns filtered colour-sensor move commands into a clamped sprite
// position stepped at a fixed rate for the VGA renderer
module color_move_ctrl
  import color_game_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int STEP_CYCLES   = 8,
  parameter int STEP          = 2,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = SCREEN_W - 1,
  parameter int Y_MIN         = 0,
  parameter int Y_MAX         = SCREEN_H - 1,
  parameter int X_INIT        = 320,
  parameter int Y_INIT        = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       is_move,
  input  logic [1:0] move,
  output logic       moving,
  output logic [1:0] dir,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       edge_hit
);
  localparam int SW = $clog2(STEP_CYCLES);
  localparam logic [10:0] L_STEP = 11'(STEP);
  logic          w_accept, w_acc_is_move;
  logic [1:0]    w_acc_move;
  state_t        r_state, w_state_nx;
  logic [1:0]    r_dir, w_dir_nx;
  logic [SW-1:0] r_step_cnt;
  logic          w_tick, w_run;
  logic [9:0]    r_pos_x, r_pos_y, w_x_nx, w_y_nx;
  logic [10:0]   w_x, w_y;
  logic          r_edge_hit, w_hit_nx;
  logic          w_clamp_up, w_clamp_dn, w_clamp_lt, w_clamp_rt;
  cmd_debounce #(.STABLE_CYCLES(STABLE_CYCLES)) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .is_move    (is_move),
    .move       (move),
    .cmd_accept (w_accept),
    .acc_is_move(w_acc_is_move),
    .acc_move   (w_acc_move)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_dir      <= DIR_UP;
      r_step_cnt <= '0;
      r_pos_x    <= 10'(X_INIT);
      r_pos_y    <= 10'(Y_INIT);
      r_edge_hit <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_dir      <= w_dir_nx;
      r_step_cnt <= w_run ? (w_tick ? '0 : r_step_cnt + 1'b1) : '0;
      r_pos_x    <= w_x_nx;
      r_pos_y    <= w_y_nx;
      r_edge_hit <= w_hit_nx;
    end
  end
  always_comb begin
    w_state_nx = r_state;
    w_dir_nx   = r_dir;
    if (w_accept) begin
      w_state_nx = w_acc_is_move ? S_MOVE : S_IDLE;
      w_dir_nx   = w_acc_is_move ? w_acc_move : r_dir;
    end
  end
  // the tick uses the pre-acceptance dir and still fires on the edge a stop is accepted
  assign w_tick = r_state == S_MOVE && enable && r_step_cnt == SW'(STEP_CYCLES - 1);
  assign w_run  = r_state == S_MOVE && w_state_nx == S_MOVE && enable;
  assign w_x = {1'b0, r_pos_x};
  assign w_y = {1'b0, r_pos_y};
  assign w_clamp_up = w_y < 11'(Y_MIN + STEP);
  assign w_clamp_dn = w_y + L_STEP > 11'(Y_MAX);
  assign w_clamp_lt = w_x < 11'(X_MIN + STEP);
  assign w_clamp_rt = w_x + L_STEP > 11'(X_MAX);
  always_comb begin
    w_x_nx   = r_pos_x;
    w_y_nx   = r_pos_y;
    w_hit_nx = 1'b0;
    if (w_tick) begin
      case (r_dir)
        DIR_UP: begin
          w_y_nx   = w_clamp_up ? 10'(Y_MIN) : 10'(w_y - L_STEP);
          w_hit_nx = w_clamp_up;
        end
        DIR_DOWN: begin
          w_y_nx   = w_clamp_dn ? 10'(Y_MAX) : 10'(w_y + L_STEP);
          w_hit_nx = w_clamp_dn;
        end
        DIR_LEFT: begin
          w_x_nx   = w_clamp_lt ? 10'(X_MIN) : 10'(w_x - L_STEP);
          w_hit_nx = w_clamp_lt;
        end
        DIR_RIGHT: begin
          w_x_nx   = w_clamp_rt ? 10'(X_MAX) : 10'(w_x + L_STEP);
          w_hit_nx = w_clamp_rt;
        end
      endcase
    end
  end
  assign moving   = r_state == S_MOVE;
  assign dir      = r_dir;
  assign pos_x    = r_pos_x;
  assign pos_y    = r_pos_y;
  assign edge_hit = r_edge_hit;
endmodule

// File: tb/tb_color_move_ctrl.sv
// tb_color_move_ctrl: directed plan scenarios plus randomized commands, checked every
// cycle against a behavioural model of acceptance, stepping and clamping
module tb_color_move_ctrl;
  localparam int SC = 4, STC = 8, ST = 2;
  localparam int XMN = 0, XMX = 19, YMN = 0, YMX = 19, XI = 10, YI = 10;
  logic       clk = 1'b0;
  logic       rst, enable, is_move;
  logic [1:0] move;
  logic       moving, edge_hit;
  logic [1:0] dir;
  logic [9:0] pos_x, pos_y;
  int n_chk = 0, n_fail = 0;
  int m_x, m_y, m_ph, m_run;
  bit m_mv, m_hit;
  logic [1:0] m_dir;
  logic [2:0] m_last;
  int sx, sy;
  always #5 clk = ~clk;
  color_move_ctrl #(
    .STABLE_CYCLES(SC), .STEP_CYCLES(STC), .STEP(ST),
    .X_MIN(XMN), .X_MAX(XMX), .Y_MIN(YMN), .Y_MAX(YMX), .X_INIT(XI), .Y_INIT(YI)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .is_move(is_move), .move(move),
    .moving(moving), .dir(dir), .pos_x(pos_x), .pos_y(pos_y), .edge_hit(edge_hit)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  task automatic model_reset();
    m_x = XI; m_y = YI; m_mv = 0; m_dir = 2'b00; m_hit = 0; m_ph = 0;
    m_last = 3'b000; m_run = 2;
  endtask
  // a command is accepted once the same raw sample has been seen on SC+1 consecutive
  // clock edges (the two reset-cleared synchroniser stages count as samples of 0)
  task automatic model_edge();
    bit tick, acc, hit;
    int nx, ny;
    logic [2:0] v;
    v = {is_move, move};
    tick = m_mv && enable && m_ph == STC - 1;
    acc = m_run == SC + 1;
    nx = m_x; ny = m_y; hit = 0;
    if (tick) begin
      case (m_dir)
        2'b00: ny = m_y - ST;
        2'b01: ny = m_y + ST;
        2'b10: nx = m_x - ST;
        2'b11: nx = m_x + ST;
      endcase
      if (nx < XMN) begin nx = XMN; hit = 1; end
      if (nx > XMX) begin nx = XMX; hit = 1; end
      if (ny < YMN) begin ny = YMN; hit = 1; end
      if (ny > YMX) begin ny = YMX; hit = 1; end
    end
    m_ph = (m_mv && enable && !(acc && !m_last[2])) ? (m_ph + 1) % STC : 0;
    if (acc) begin
      if (m_last[2]) begin m_mv = 1; m_dir = m_last[1:0]; end
      else m_mv = 0;
    end
    m_run = (v == m_last) ? (m_run < 1000 ? m_run + 1 : m_run) : 1;
    m_last = v;
    m_x = nx; m_y = ny; m_hit = hit;
  endtask
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("moving", 32'(moving), 32'(m_mv));
    chk("dir", 32'(dir), 32'(m_dir));
    chk("pos_x", 32'(pos_x), 32'(m_x));
    chk("pos_y", 32'(pos_y), 32'(m_y));
    chk("edge_hit", 32'(edge_hit), 32'(m_hit));
  endtask
  task automatic drive(input logic im, input logic [1:0] mv, input int n);
    is_move = im; move = mv;
    repeat (n) cyc();
  endtask
  initial begin
    rst = 1'b1; enable = 1'b1; is_move = 1'b0; move = 2'b00;
    model_reset();
    #12;
    chk("rst_pos_x", 32'(pos_x), 32'd10);
    chk("rst_pos_y", 32'(pos_y), 32'd10);
    chk("rst_moving", 32'(moving), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_edge_hit", 32'(edge_hit), 32'd0);
    @(negedge clk); rst = 1'b0;
    // move right: accepted exactly 6 cycles after the change, then steps every 8
    drive(1'b1, 2'b11, 5);
    chk("lat_early", 32'(moving), 32'd0);
    cyc();
    chk("lat_moving", 32'(moving), 32'd1);
    chk("lat_dir", 32'(dir), 32'd3);
    for (int i = 0; i < 4; i++) begin
      repeat (STC) cyc();
      chk("right_step", 32'(pos_x), 32'(12 + 2 * i));
    end
    repeat (STC) cyc();
    chk("clamp_x", 32'(pos_x), 32'd19);
    chk("clamp_hit", 32'(edge_hit), 32'd1);
    cyc();
    chk("clamp_hit_pulse", 32'(edge_hit), 32'd0);
    repeat (STC - 1) cyc();
    chk("clamp_x_again", 32'(pos_x), 32'd19);
    chk("clamp_hit_again", 32'(edge_hit), 32'd1);
    chk("clamp_y", 32'(pos_y), 32'd10);
    // direction change to up, then stop and stay frozen
    drive(1'b1, 2'b00, 5);
    chk("turn_early", 32'(dir), 32'd3);
    cyc();
    chk("turn_dir", 32'(dir), 32'd0);
    chk("turn_moving", 32'(moving), 32'd1);
    repeat (20) cyc();
    drive(1'b0, 2'b00, 10);
    chk("stop_moving", 32'(moving), 32'd0);
    chk("stop_dir", 32'(dir), 32'd0);
    sx = m_x; sy = m_y;
    repeat (50) cyc();
    chk("frozen_x", 32'(pos_x), 32'(sx));
    chk("frozen_y", 32'(pos_y), 32'(sy));
    // short glitch must be ignored
    drive(1'b1, 2'b10, 3);
    drive(1'b0, 2'b00, 20);
    chk("glitch_moving", 32'(moving), 32'd0);
    chk("glitch_x", 32'(pos_x), 32'(sx));
    chk("glitch_y", 32'(pos_y), 32'(sy));
    // async reset between ticks while moving left
    drive(1'b1, 2'b10, 6 + STC + 3);
    chk("pre_rst_moving", 32'(moving), 32'd1);
    #2 rst = 1'b1; is_move = 1'b0; move = 2'b00;
    #1;
    model_reset();
    chk("arst_pos_x", 32'(pos_x), 32'd10);
    chk("arst_pos_y", 32'(pos_y), 32'd10);
    chk("arst_moving", 32'(moving), 32'd0);
    chk("arst_dir", 32'(dir), 32'd0);
    chk("arst_edge_hit", 32'(edge_hit), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (30) cyc();
    chk("post_rst_x", 32'(pos_x), 32'd10);
    // randomized commands with occasional enable drops
    repeat (400) begin
      is_move = 1'($urandom);
      move = 2'($urandom);
      enable = $urandom_range(0, 7) != 0;
      repeat ($urandom_range(1, 40)) cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
